// File: rtl/tlc_conflict_monitor_if.sv
// ---------------------------------------------------------------------------
// tlc_conflict_monitor_if
// Bundle between the lamp source (traffic_control or a bench) and the
// conflict monitor.
//   L_A, L_B    lamp patterns, one-hot {red,yellow,green}
//   err_clr     fault clear request (level)
//   ERR         registered fault flag back to the controller
//   fault_code  code of the latched fault, 0 = none
//   fault_cnt   saturating count of fault entries (0 when counting disabled)
//   state       monitor FSM state for observation (0=MASK, 1=RUN, 2=FAULT)
// Handshake: there is no valid/ready pair. Lamps are sampled on every rising
// clock edge, and ERR/fault_code are valid from the edge that latched them.
// ---------------------------------------------------------------------------
interface tlc_conflict_monitor_if;
    logic [2:0] L_A;
    logic [2:0] L_B;
    logic       err_clr;
    logic       ERR;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;
    logic [1:0] state;

    modport master (
        output L_A, L_B, err_clr,
        input  ERR, fault_code, fault_cnt, state
    );

    modport slave (
        input  L_A, L_B, err_clr,
        output ERR, fault_code, fault_cnt, state
    );
endinterface

// File: rtl/tlc_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tlc_conflict_monitor
// Safety monitor for traffic_control. It samples both lamp groups every cycle
// and checks the following properties:
//   1 invalid encoding, 2 conflict (no red), 3 illegal sequence,
//   4 short yellow, 5 stuck pattern.
// The lowest code wins. The first violation seen in RUN is latched, and ERR
// is raised until err_clr arrives together with all-red lamps.
// Ports:
//   CLK    system clock, rising edge
//   reset  asynchronous active-high reset
//   mon    tlc_conflict_monitor_if.slave (lamps, err_clr in; ERR, fault_code,
//          fault_cnt, state out)
// Optional feature macro: TLC_MON_FAULT_COUNT_EN
//   When defined, fault_cnt counts RUN->FAULT entries and saturates at 8'hFF.
//   When undefined, fault_cnt is tied to 8'h00.
// ---------------------------------------------------------------------------
module tlc_conflict_monitor #(
    parameter int MIN_YEL  = 2,
    parameter int MAX_HOLD = 64,
    parameter int STARTUP  = 4
) (
    input logic                  CLK,
    input logic                  reset,
    tlc_conflict_monitor_if.slave mon
);
    localparam int CW = $clog2(MAX_HOLD + 2);
    localparam int MW = $clog2(STARTUP + 1);

    localparam logic [2:0]    RED = 3'b100;
    localparam logic [2:0]    YEL = 3'b010;
    localparam logic [2:0]    GRN = 3'b001;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD + 1);
    localparam logic [CW-1:0] YEL_SAT   = CW'(MIN_YEL);
    localparam logic [MW-1:0] MASK_LAST = MW'(STARTUP - 1);

    typedef enum logic [1:0] {
        S_MASK  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t        state;
    logic [MW-1:0] mask_cnt;
    logic [2:0]    prev_a, prev_b;
    logic [CW-1:0] hold_a, hold_b, yel_a, yel_b;
    logic [CW-1:0] hold_a_nxt, hold_b_nxt, yel_a_nxt, yel_b_nxt;
    logic          err_q;
    logic [2:0]    code_q;
    logic [2:0]    viol;

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    // A repeated pattern is always a legal step. Only R->G, G->Y and Y->R
    // may change the pattern.
    function automatic logic is_legal(input logic [2:0] p, input logic [2:0] c);
        return (c == p) || (p == RED && c == GRN) ||
               (p == GRN && c == YEL) || (p == YEL && c == RED);
    endfunction

    // The hold counters count consecutive samples of one pattern, including
    // the current sample. A changed sample therefore counts as the first
    // sample of the new pattern.
    always_comb begin
        hold_a_nxt = (mon.L_A != prev_a) ? CNT_ONE :
                     (hold_a == HOLD_SAT) ? HOLD_SAT : hold_a + CNT_ONE;
        hold_b_nxt = (mon.L_B != prev_b) ? CNT_ONE :
                     (hold_b == HOLD_SAT) ? HOLD_SAT : hold_b + CNT_ONE;
        yel_a_nxt  = (mon.L_A != YEL) ? '0 :
                     (yel_a == YEL_SAT) ? YEL_SAT : yel_a + CNT_ONE;
        yel_b_nxt  = (mon.L_B != YEL) ? '0 :
                     (yel_b == YEL_SAT) ? YEL_SAT : yel_b + CNT_ONE;
    end

    // Violation code for the current sample, with the lowest code first.
    // The registered yel_* hold the yellow run that ended with prev_*.
    always_comb begin
        viol = 3'd0;
        if (!is_onehot(mon.L_A) || !is_onehot(mon.L_B))
            viol = 3'd1;
        else if (mon.L_A != RED && mon.L_B != RED)
            viol = 3'd2;
        else if (!is_legal(prev_a, mon.L_A) || !is_legal(prev_b, mon.L_B))
            viol = 3'd3;
        else if ((prev_a == YEL && mon.L_A == RED && yel_a < YEL_SAT) ||
                 (prev_b == YEL && mon.L_B == RED && yel_b < YEL_SAT))
            viol = 3'd4;
        else if (hold_a_nxt == HOLD_SAT || hold_b_nxt == HOLD_SAT)
            viol = 3'd5;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= S_MASK;
            mask_cnt <= '0;
            prev_a   <= RED;
            prev_b   <= RED;
            hold_a   <= '0;
            hold_b   <= '0;
            yel_a    <= '0;
            yel_b    <= '0;
            err_q    <= 1'b0;
            code_q   <= 3'd0;
        end else begin
            // History keeps tracking the lamps in every state.
            prev_a <= mon.L_A;
            prev_b <= mon.L_B;
            hold_a <= hold_a_nxt;
            hold_b <= hold_b_nxt;
            yel_a  <= yel_a_nxt;
            yel_b  <= yel_b_nxt;
            case (state)
                S_MASK: begin
                    if (mask_cnt == MASK_LAST) state <= S_RUN;
                    else mask_cnt <= mask_cnt + 1'b1;
                end
                S_RUN: begin
                    if (viol != 3'd0) begin
                        state  <= S_FAULT;
                        err_q  <= 1'b1;
                        code_q <= viol;
                    end
                end
                S_FAULT: begin
                    if (mon.err_clr && mon.L_A == RED && mon.L_B == RED) begin
                        state  <= S_RUN;
                        err_q  <= 1'b0;
                        code_q <= 3'd0;
                        hold_a <= '0;
                        hold_b <= '0;
                        yel_a  <= '0;
                        yel_b  <= '0;
                    end
                end
                default: state <= S_MASK;
            endcase
        end
    end

`ifdef TLC_MON_FAULT_COUNT_EN
    logic [7:0] fcnt_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            fcnt_q <= 8'h00;
        else if (state == S_RUN && viol != 3'd0 && fcnt_q != 8'hFF)
            fcnt_q <= fcnt_q + 8'h01;
    end

    assign mon.fault_cnt = fcnt_q;
`else
    assign mon.fault_cnt = 8'h00;
`endif

    assign mon.ERR        = err_q;
    assign mon.fault_code = code_q;
    assign mon.state      = state;
endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tb_tlc_conflict_monitor
// Directed bench for tlc_conflict_monitor with the default parameters
// (MIN_YEL=2, MAX_HOLD=64, STARTUP=4). The expected values are worked out
// by hand from the monitor's behaviour.
// ---------------------------------------------------------------------------
module tb_tlc_conflict_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

`ifdef TLC_MON_FAULT_COUNT_EN
    localparam logic [7:0] EXP_CNT_FIRST = 8'd1;
    localparam logic [7:0] EXP_CNT_FINAL = 8'd5;
`else
    localparam logic [7:0] EXP_CNT_FIRST = 8'd0;
    localparam logic [7:0] EXP_CNT_FINAL = 8'd0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    tlc_conflict_monitor_if bus();

    tlc_conflict_monitor dut (
        .CLK   (clk),
        .reset (reset),
        .mon   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one lamp sample, let the rising edge take it, then settle.
    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic clr);
        bus.L_A     = a;
        bus.L_B     = b;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.L_A     = R;
        bus.L_B     = R;
        bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_err",   32'(bus.ERR),        32'd0);
        check("rst_code",  32'(bus.fault_code), 32'd0);
        check("rst_cnt",   32'(bus.fault_cnt),  32'd0);
        check("rst_state", 32'(bus.state),      32'd0);
        reset = 1'b0;

        // Startup mask: the FSM leaves MASK on the 4th sample.
        drive(G, R, 1'b0);
        drive(G, R, 1'b0);
        drive(G, R, 1'b0);
        check("mask_hold", 32'(bus.state), 32'd0);
        drive(G, R, 1'b0);
        check("mask_done", 32'(bus.state), 32'd1);
        drive(G, R, 1'b1);
        check("run_clr_err",   32'(bus.ERR),   32'd0);
        check("run_clr_state", 32'(bus.state), 32'd1);
        drive(G, R, 1'b0);
        check("run_code", 32'(bus.fault_code), 32'd0);

        // Conflict: both directions green.
        drive(G, G, 1'b0);
        check("confl_err",  32'(bus.ERR),        32'd1);
        check("confl_code", 32'(bus.fault_code), 32'd2);
        check("confl_cnt",  32'(bus.fault_cnt),  32'(EXP_CNT_FIRST));
        drive(G, R, 1'b0);
        check("confl_hold", 32'(bus.fault_code), 32'd2);
        drive(G, R, 1'b1);
        check("clr_notred_err",  32'(bus.ERR),        32'd1);
        check("clr_notred_code", 32'(bus.fault_code), 32'd2);
        drive(R, R, 1'b1);
        check("clr_err",   32'(bus.ERR),        32'd0);
        check("clr_code",  32'(bus.fault_code), 32'd0);
        check("clr_state", 32'(bus.state),      32'd1);

        // G -> R with no yellow.
        drive(G, R, 1'b0);
        check("seq_pre", 32'(bus.ERR), 32'd0);
        drive(R, R, 1'b0);
        check("seq_code", 32'(bus.fault_code), 32'd3);
        drive(R, R, 1'b1);

        // Yellow held for only one sample.
        drive(G, R, 1'b0);
        drive(Y, R, 1'b0);
        check("shorty_pre", 32'(bus.ERR), 32'd0);
        drive(R, R, 1'b0);
        check("shorty_code", 32'(bus.fault_code), 32'd4);
        drive(R, R, 1'b1);

        // Yellow held for exactly MIN_YEL samples is legal.
        drive(G, R, 1'b0);
        drive(Y, R, 1'b0);
        drive(Y, R, 1'b0);
        drive(R, R, 1'b0);
        check("yel_ok_err",  32'(bus.ERR),        32'd0);
        check("yel_ok_code", 32'(bus.fault_code), 32'd0);

        // Invalid encoding beats conflict.
        drive(3'b011, G, 1'b0);
        check("prio_code", 32'(bus.fault_code), 32'd1);
        drive(R, R, 1'b1);

        // Stuck: the 65th identical sample trips the check.
        for (int i = 0; i < 64; i++) drive(G, R, 1'b0);
        check("hold64_err", 32'(bus.ERR), 32'd0);
        drive(G, R, 1'b0);
        check("stuck_code", 32'(bus.fault_code), 32'd5);
        check("stuck_err",  32'(bus.ERR),        32'd1);
        check("final_cnt",  32'(bus.fault_cnt),  32'(EXP_CNT_FINAL));

        // Asynchronous reset in the middle of a fault.
        #2;
        reset = 1'b1;
        #1;
        check("areset_err",   32'(bus.ERR),        32'd0);
        check("areset_code",  32'(bus.fault_code), 32'd0);
        check("areset_cnt",   32'(bus.fault_cnt),  32'd0);
        check("areset_state", 32'(bus.state),      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Violations during the startup mask are ignored.
        drive(G, G, 1'b0);
        check("mask_ignore", 32'(bus.ERR), 32'd0);
        drive(G, R, 1'b0);
        drive(G, R, 1'b0);
        drive(G, R, 1'b0);
        drive(G, R, 1'b0);
        check("remask_err",   32'(bus.ERR),   32'd0);
        check("remask_state", 32'(bus.state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
